// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared widths, source encoding and FIFO payload layouts
// for the common data bus arbiter.
`ifndef DATA_LEN
`define DATA_LEN 32
`endif
`ifndef ROB_LEN
`define ROB_LEN 4
`endif

package cdb_arbiter_pkg;

   localparam int unsigned DATA_LEN = `DATA_LEN;
   localparam int unsigned ROB_LEN  = `ROB_LEN;

   typedef enum logic {
      CDB_SRC_ALU = 1'b0,
      CDB_SRC_LSB = 1'b1
   } cdb_src_e;

   typedef struct packed {
      logic                isjump;
      logic [DATA_LEN-1:0] jumpto;
      logic [DATA_LEN-1:0] val;
      logic [ROB_LEN-1:0]  robpos;
   } alu_entry_t;

   typedef struct packed {
      logic [DATA_LEN-1:0] val;
      logic [ROB_LEN-1:0]  robpos;
   } lsb_entry_t;

endpackage

// File: rtl/cdb_arbiter_fifo.sv
// cdb_fifo: small skid FIFO with head/tail/count, synchronous flush and
// asynchronous active-low reset. Pushes while full are dropped here.
module cdb_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = 2,
   parameter int unsigned W     = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head_data,
   output logic         full,
   output logic         empty
);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign full      = (count == (PTR_W+1)'(DEPTH));
   assign empty     = (count == '0);
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign head_data = mem[head];

   // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_push) tail <= tail + 1'b1;
         if (do_pop)  head <= head + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // Entry storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[tail] <= push_data;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter sharing the ROB result-write port between
// the ALU and the LSB load path, driving a registered common data bus.
// Optional: define CDB_PERF_EN to add the conflict_cnt output.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ready,
   input  logic                clear,
   input  logic                alu_flag,
   input  logic [DATA_LEN-1:0] alu_val,
   input  logic                alu_isjump,
   input  logic [DATA_LEN-1:0] alu_jumpto,
   input  logic [ROB_LEN-1:0]  alu_robpos,
   output logic                alu_stall,
   input  logic                lsb_flag,
   input  logic [DATA_LEN-1:0] lsb_val,
   input  logic [ROB_LEN-1:0]  lsb_robpos,
   output logic                lsb_stall,
   output logic                cdb_flag,
   output logic                cdb_src,
   output logic [DATA_LEN-1:0] cdb_val,
   output logic                cdb_isjump,
   output logic [DATA_LEN-1:0] cdb_jumpto,
   output logic [ROB_LEN-1:0]  cdb_robpos,
   output logic                cdb_ovf
`ifdef CDB_PERF_EN
   ,
   output logic [31:0]         conflict_cnt
`endif
);

   alu_entry_t alu_live, alu_head, alu_sel;
   lsb_entry_t lsb_live, lsb_head, lsb_sel;
   logic       alu_full, alu_empty, alu_cand, alu_push, alu_pop, alu_take_live;
   logic       lsb_full, lsb_empty, lsb_cand, lsb_push, lsb_pop, lsb_take_live;
   logic       arb_en, both_cand, grant_any;
   cdb_src_e   grant_src, last_grant;

   assign alu_live  = {alu_isjump, alu_jumpto, alu_val, alu_robpos};
   assign lsb_live  = {lsb_val, lsb_robpos};
   assign alu_stall = alu_full;
   assign lsb_stall = lsb_full;

   cdb_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .W($bits(alu_entry_t))) u_alu_fifo (
      .clk(clk), .reset(reset), .flush(clear),
      .push(alu_push), .push_data(alu_live), .pop(alu_pop),
      .head_data(alu_head), .full(alu_full), .empty(alu_empty)
   );

   cdb_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .W($bits(lsb_entry_t))) u_lsb_fifo (
      .clk(clk), .reset(reset), .flush(clear),
      .push(lsb_push), .push_data(lsb_live), .pop(lsb_pop),
      .head_data(lsb_head), .full(lsb_full), .empty(lsb_empty)
   );

   // Candidate selection, round-robin grant and FIFO push/pop steering.
   // A granted live input bypasses its (empty) FIFO instead of being written.
   always_comb begin
      arb_en    = ready && !clear;
      alu_cand  = !alu_empty || alu_flag;
      lsb_cand  = !lsb_empty || lsb_flag;
      both_cand = alu_cand && lsb_cand;
      grant_any = arb_en && (alu_cand || lsb_cand);
      grant_src = CDB_SRC_ALU;
      if (both_cand)
         grant_src = (last_grant == CDB_SRC_ALU) ? CDB_SRC_LSB : CDB_SRC_ALU;
      else if (lsb_cand)
         grant_src = CDB_SRC_LSB;
      alu_sel       = alu_empty ? alu_live : alu_head;
      lsb_sel       = lsb_empty ? lsb_live : lsb_head;
      alu_pop       = grant_any && (grant_src == CDB_SRC_ALU) && !alu_empty;
      lsb_pop       = grant_any && (grant_src == CDB_SRC_LSB) && !lsb_empty;
      alu_take_live = grant_any && (grant_src == CDB_SRC_ALU) && alu_empty;
      lsb_take_live = grant_any && (grant_src == CDB_SRC_LSB) && lsb_empty;
      alu_push      = alu_flag && !clear && !alu_take_live;
      lsb_push      = lsb_flag && !clear && !lsb_take_live;
   end

   // CDB output registers, grant history and sticky overflow flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cdb_flag   <= 1'b0;
         cdb_src    <= 1'b0;
         cdb_val    <= '0;
         cdb_isjump <= 1'b0;
         cdb_jumpto <= '0;
         cdb_robpos <= '0;
         cdb_ovf    <= 1'b0;
         last_grant <= CDB_SRC_LSB;
      end else begin
         if (!clear && ((alu_flag && alu_full) || (lsb_flag && lsb_full)))
            cdb_ovf <= 1'b1;
         if (clear) begin
            cdb_flag   <= 1'b0;
            last_grant <= CDB_SRC_LSB;
         end else if (grant_any) begin
            cdb_flag   <= 1'b1;
            cdb_src    <= grant_src;
            last_grant <= grant_src;
            if (grant_src == CDB_SRC_ALU) begin
               cdb_val    <= alu_sel.val;
               cdb_isjump <= alu_sel.isjump;
               cdb_jumpto <= alu_sel.jumpto;
               cdb_robpos <= alu_sel.robpos;
            end else begin
               cdb_val    <= lsb_sel.val;
               cdb_isjump <= 1'b0;
               cdb_jumpto <= '0;
               cdb_robpos <= lsb_sel.robpos;
            end
         end else begin
            cdb_flag <= 1'b0;
         end
      end
   end

`ifdef CDB_PERF_EN
   // Saturating count of arbitration cycles with both sources competing.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         conflict_cnt <= '0;
      else if (arb_en && both_cand && (conflict_cnt != '1))
         conflict_cnt <= conflict_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vectors with a scoreboard queue of expected CDB
// results consumed by an independent monitor.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   logic                clk = 1'b0;
   logic                reset, ready, clear;
   logic                alu_flag, alu_isjump, lsb_flag;
   logic [DATA_LEN-1:0] alu_val, alu_jumpto, lsb_val;
   logic [ROB_LEN-1:0]  alu_robpos, lsb_robpos;
   logic                alu_stall, lsb_stall;
   logic                cdb_flag, cdb_src, cdb_isjump, cdb_ovf;
   logic [DATA_LEN-1:0] cdb_val, cdb_jumpto;
   logic [ROB_LEN-1:0]  cdb_robpos;
`ifdef CDB_PERF_EN
   logic [31:0]         conflict_cnt;
`endif

   typedef struct packed {
      logic                src;
      logic [DATA_LEN-1:0] val;
      logic                isjump;
      logic [DATA_LEN-1:0] jumpto;
      logic [ROB_LEN-1:0]  robpos;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_exp, mon_got;
   int   vectors = 0;
   int   miscompares = 0;

   cdb_arbiter #(.DEPTH(4), .PTR_W(2)) dut (
      .clk(clk), .reset(reset), .ready(ready), .clear(clear),
      .alu_flag(alu_flag), .alu_val(alu_val), .alu_isjump(alu_isjump),
      .alu_jumpto(alu_jumpto), .alu_robpos(alu_robpos), .alu_stall(alu_stall),
      .lsb_flag(lsb_flag), .lsb_val(lsb_val), .lsb_robpos(lsb_robpos),
      .lsb_stall(lsb_stall),
      .cdb_flag(cdb_flag), .cdb_src(cdb_src), .cdb_val(cdb_val),
      .cdb_isjump(cdb_isjump), .cdb_jumpto(cdb_jumpto), .cdb_robpos(cdb_robpos),
      .cdb_ovf(cdb_ovf)
`ifdef CDB_PERF_EN
      , .conflict_cnt(conflict_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Monitor: every CDB pulse must match the oldest expected result.
   always @(negedge clk) begin
      if (reset && cdb_flag) begin
         vectors++;
         mon_got = {cdb_src, cdb_val, cdb_isjump, cdb_jumpto, cdb_robpos};
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL cdb_unexpected: got src=%0d val=%h robpos=%0d, required no pulse",
                     cdb_src, cdb_val, cdb_robpos);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp) begin
               miscompares++;
               $display("FAIL cdb_result: got src=%0d val=%h isjump=%0d jumpto=%h robpos=%0d, required src=%0d val=%h isjump=%0d jumpto=%h robpos=%0d",
                        mon_got.src, mon_got.val, mon_got.isjump, mon_got.jumpto, mon_got.robpos,
                        mon_exp.src, mon_exp.val, mon_exp.isjump, mon_exp.jumpto, mon_exp.robpos);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic exp_alu(input logic [DATA_LEN-1:0] v, input logic j,
                          input logic [DATA_LEN-1:0] jt, input logic [ROB_LEN-1:0] rp);
      exp_q.push_back({1'b0, v, j, jt, rp});
   endtask

   task automatic exp_lsb(input logic [DATA_LEN-1:0] v, input logic [ROB_LEN-1:0] rp);
      exp_q.push_back({1'b1, v, 1'b0, {DATA_LEN{1'b0}}, rp});
   endtask

   task automatic set_alu(input logic [DATA_LEN-1:0] v, input logic j,
                          input logic [DATA_LEN-1:0] jt, input logic [ROB_LEN-1:0] rp);
      alu_flag = 1'b1; alu_val = v; alu_isjump = j; alu_jumpto = jt; alu_robpos = rp;
   endtask

   task automatic set_lsb(input logic [DATA_LEN-1:0] v, input logic [ROB_LEN-1:0] rp);
      lsb_flag = 1'b1; lsb_val = v; lsb_robpos = rp;
   endtask

   task automatic idle_inputs();
      alu_flag = 1'b0; lsb_flag = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      ready = 1'b1; clear = 1'b0;
      reset = 1'b0;
      exp_q.delete();
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL %s: got %0d results still pending, required 0", name, exp_q.size());
      end
   endtask

   // Watchdog so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0; ready = 1'b1; clear = 1'b0;
      alu_flag = 1'b0; alu_val = '0; alu_isjump = 1'b0; alu_jumpto = '0; alu_robpos = '0;
      lsb_flag = 1'b0; lsb_val = '0; lsb_robpos = '0;
      tick();
      // Reset state
      check("rst_flag",   64'(cdb_flag),   64'd0);
      check("rst_src",    64'(cdb_src),    64'd0);
      check("rst_val",    64'(cdb_val),    64'd0);
      check("rst_isjump", 64'(cdb_isjump), 64'd0);
      check("rst_jumpto", 64'(cdb_jumpto), 64'd0);
      check("rst_robpos", 64'(cdb_robpos), 64'd0);
      check("rst_ovf",    64'(cdb_ovf),    64'd0);
      check("rst_astall", 64'(alu_stall),  64'd0);
      check("rst_lstall", 64'(lsb_stall),  64'd0);
      reset = 1'b1;
      tick();

      // 1: idle fall-through, one-cycle latency
      set_alu(32'h11, 1'b1, 32'h100, 4'd3);
      exp_alu(32'h11, 1'b1, 32'h100, 4'd3);
      tick();
      idle_inputs();
      check("t1_latency", 64'(cdb_flag), 64'd1);
      check("t1_val",     64'(cdb_val),  64'h11);
      wait_drain("t1_drain");
      repeat (3) tick();

      // 2: tie after reset, then sustained dual pushes alternate
      do_reset();
      for (int k = 0; k < 6; k++) begin
         if (k == 0) begin
            set_alu(32'hA, 1'b0, 32'h0, 4'd1);
            set_lsb(32'hB, 4'd2);
         end else begin
            set_alu(32'h20 + k, 1'b0, 32'h0, 4'(k));
            set_lsb(32'h40 + k, 4'(8 + k));
         end
         exp_alu(alu_val, 1'b0, 32'h0, alu_robpos);
         exp_lsb(lsb_val, lsb_robpos);
         tick();
      end
      idle_inputs();
      wait_drain("t2_drain");
      check("t2_astall", 64'(alu_stall), 64'd0);

      // 3: fill LSB FIFO while stalled, overflow, then drain in order
      do_reset();
      ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("t3_stall_pre", 64'(lsb_stall), 64'd0);
         set_lsb(32'h30 + k, 4'(4 + k));
         exp_lsb(lsb_val, lsb_robpos);
         tick();
      end
      idle_inputs();
      check("t3_stall_full", 64'(lsb_stall), 64'd1);
      check("t3_ovf_pre",    64'(cdb_ovf),   64'd0);
      set_lsb(32'h99, 4'd15);
      tick();
      idle_inputs();
      check("t3_ovf",        64'(cdb_ovf),   64'd1);
      check("t3_stall_held", 64'(lsb_stall), 64'd1);
      ready = 1'b1;
      tick();
      check("t3_stall_drop", 64'(lsb_stall), 64'd0);
      wait_drain("t3_drain");
      check("t3_ovf_sticky", 64'(cdb_ovf), 64'd1);

      // 4: flush drops queued entries and a same-cycle push
      do_reset();
      ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         set_alu(32'h50 + k, 1'b0, 32'h0, 4'(k));
         tick();
      end
      alu_flag = 1'b0;
      clear = 1'b1; ready = 1'b1;
      set_lsb(32'h77, 4'd5);
      tick();
      clear = 1'b0;
      idle_inputs();
      check("t4_flag",   64'(cdb_flag),  64'd0);
      check("t4_astall", 64'(alu_stall), 64'd0);
      check("t4_ovf",    64'(cdb_ovf),   64'd0);
      repeat (4) tick();
      set_alu(32'h61, 1'b0, 32'h0, 4'd9);
      exp_alu(32'h61, 1'b0, 32'h0, 4'd9);
      tick();
      idle_inputs();
      check("t4_empty_ft", 64'(cdb_val), 64'h61);
      wait_drain("t4_drain");

      // 5: asynchronous reset in the middle of a grant burst
      do_reset();
      for (int k = 0; k < 3; k++) begin
         set_alu(32'h80 + k, 1'b0, 32'h0, 4'(k));
         set_lsb(32'h90 + k, 4'(8 + k));
         exp_alu(alu_val, 1'b0, 32'h0, alu_robpos);
         exp_lsb(lsb_val, lsb_robpos);
         tick();
      end
      idle_inputs();
      #2;
      reset = 1'b0;
      #1;
      check("t5_flag",   64'(cdb_flag),   64'd0);
      check("t5_src",    64'(cdb_src),    64'd0);
      check("t5_val",    64'(cdb_val),    64'd0);
      check("t5_robpos", 64'(cdb_robpos), 64'd0);
      exp_q.delete();
      @(negedge clk);
      reset = 1'b1;
      set_alu(32'hC1, 1'b0, 32'h0, 4'd3);
      set_lsb(32'hD1, 4'd4);
      exp_alu(32'hC1, 1'b0, 32'h0, 4'd3);
      exp_lsb(32'hD1, 4'd4);
      tick();
      idle_inputs();
      check("t5_first_src", 64'(cdb_src), 64'd0);
      wait_drain("t5_drain");

`ifdef CDB_PERF_EN
      // 6: conflict counter counts only enabled dual-candidate cycles
      do_reset();
      check("t6_cnt_rst", 64'(conflict_cnt), 64'd0);
      for (int k = 0; k < 5; k++) begin
         set_alu(32'hE0 + k, 1'b0, 32'h0, 4'(k));
         set_lsb(32'hF0 + k, 4'(8 + k));
         tick();
      end
      idle_inputs();
      exp_alu(32'hE0, 1'b0, 32'h0, 4'd0);
      exp_lsb(32'hF0, 4'd8);
      exp_alu(32'hE1, 1'b0, 32'h0, 4'd1);
      exp_lsb(32'hF1, 4'd9);
      exp_alu(32'hE2, 1'b0, 32'h0, 4'd2);
      ready = 1'b0;
      tick();
      tick();
      check("t6_cnt", 64'(conflict_cnt), 64'd5);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      ready = 1'b1;
      tick();
      check("t6_cnt_clear", 64'(conflict_cnt), 64'd5);
      wait_drain("t6_drain");
`endif

      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
